// File: rtl/finj_chk_pkg.sv
// Shared types and elaboration-time parameter checks for the lockstep checker.
package finj_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  function automatic bit lat_ok(input int lat);
    return (lat >= 1);
  endfunction

  function automatic bit lanes_ok(input int lanes);
    return (lanes >= 1) && (lanes <= 8);
  endfunction

endpackage

// File: rtl/finj_valid_delay.sv
// LAT-deep valid shift register that tracks in-flight DUT operations up to the compare point.
module finj_valid_delay #(
  parameter int LAT = 2
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  input  logic in_vld,
  output logic out_vld
);

  logic [LAT-1:0] stages;

  // A shift-and-or form works for LAT==1 as well, avoiding a zero-width slice.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stages <= '0;
    end else begin
      stages <= (stages << 1) | LAT'(in_vld);
    end
  end

  assign out_vld = stages[LAT-1];

endmodule

// File: rtl/finj_lockstep_checker.sv
// Golden/faulty machine lockstep checker with mismatch counter and sticky lane flags.
// Optional first-mismatch capture ports are enabled by FINJ_FIRST_MISMATCH_CAPTURE_EN.
module finj_lockstep_checker
  import finj_chk_pkg::*;
#(
  parameter int OP_W    = 32,
  parameter int DATA_W  = 16,
  parameter int LANES   = 2,
  parameter int LAT     = 2,
  parameter int CNT_W   = 32,
  parameter int TOTAL_W = 16
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic                    start,
  input  logic [TOTAL_W-1:0]      total,
  input  logic                    src_vld,
  output logic                    src_rdy,
  input  logic [OP_W-1:0]         src_a,
  input  logic [OP_W-1:0]         src_b,
  output logic [OP_W-1:0]         dut_op_a,
  output logic [OP_W-1:0]         dut_op_b,
  output logic                    dut_pvld,
  input  logic [LANES*DATA_W-1:0] gm_res,
  input  logic [LANES*DATA_W-1:0] fm_res,
  output logic                    chk_vld,
  output logic [LANES-1:0]        chk_mismatch,
  output logic [CNT_W-1:0]        mis_cnt,
  output logic [LANES-1:0]        lane_err,
  output logic                    busy,
  output logic                    done
`ifdef FINJ_FIRST_MISMATCH_CAPTURE_EN
  ,
  output logic [TOTAL_W-1:0]      first_idx,
  output logic [LANES*DATA_W-1:0] first_gm,
  output logic [LANES*DATA_W-1:0] first_fm,
  output logic                    first_vld
`endif
);

  if (!lat_ok(LAT)) begin : g_bad_lat
    $error("finj_lockstep_checker: LAT must be >= 1");
  end
  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("finj_lockstep_checker: LANES must be in 1..8");
  end

  chk_state_e         state, state_nxt;
  logic [TOTAL_W-1:0] total_q;
  logic [TOTAL_W-1:0] issued;
  logic [TOTAL_W-1:0] issued_inc;
  logic [TOTAL_W-1:0] checked;
  logic               start_ok;
  logic               handshake;
  logic               cmp_vld;
  logic [LANES-1:0]   lane_diff;

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign src_rdy    = (state == RUN) && (issued < total_q);
  assign handshake  = src_vld && src_rdy;
  assign issued_inc = issued + 1'b1;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (total == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (handshake && (issued_inc == total_q)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (checked == total_q) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  finj_valid_delay #(
    .LAT(LAT)
  ) u_valid_delay (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .in_vld         (dut_pvld),
    .out_vld        (cmp_vld)
  );

  always_comb begin
    lane_diff = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_diff[i] = (gm_res[i*DATA_W +: DATA_W] != fm_res[i*DATA_W +: DATA_W]);
    end
  end

  // Operand issue register: operands hold through gaps so the DUT inputs stay quiet.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dut_op_a <= '0;
      dut_op_b <= '0;
      dut_pvld <= 1'b0;
    end else begin
      dut_pvld <= handshake;
      if (handshake) begin
        dut_op_a <= src_a;
        dut_op_b <= src_b;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      total_q      <= '0;
      issued       <= '0;
      checked      <= '0;
      mis_cnt      <= '0;
      lane_err     <= '0;
      chk_vld      <= 1'b0;
      chk_mismatch <= '0;
    end else begin
      chk_vld      <= cmp_vld;
      chk_mismatch <= cmp_vld ? lane_diff : '0;
      if (start_ok) begin
        total_q  <= total;
        issued   <= '0;
        checked  <= '0;
        mis_cnt  <= '0;
        lane_err <= '0;
      end else begin
        if (handshake) begin
          issued <= issued_inc;
        end
        if (cmp_vld) begin
          checked  <= checked + 1'b1;
          lane_err <= lane_err | lane_diff;
          if ((|lane_diff) && (mis_cnt != {CNT_W{1'b1}})) begin
            mis_cnt <= mis_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef FINJ_FIRST_MISMATCH_CAPTURE_EN
  // Results return in issue order, so the checked count is the operation index.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      first_vld <= 1'b0;
      first_idx <= '0;
      first_gm  <= '0;
      first_fm  <= '0;
    end else if (start_ok) begin
      first_vld <= 1'b0;
      first_idx <= '0;
      first_gm  <= '0;
      first_fm  <= '0;
    end else if (cmp_vld && (|lane_diff) && !first_vld) begin
      first_vld <= 1'b1;
      first_idx <= checked;
      first_gm  <= gm_res;
      first_fm  <= fm_res;
    end
  end
`endif

endmodule

// File: tb/tb_finj_lockstep_checker.sv
// Randomized self-checking bench for finj_lockstep_checker with a behavioural GM/FM pair and reference model.
module tb_finj_lockstep_checker;

  localparam int OP_W    = 32;
  localparam int DATA_W  = 16;
  localparam int LANES   = 2;
  localparam int LAT     = 2;
  localparam int CNT_W   = 32;
  localparam int TOTAL_W = 16;
  localparam int RW      = LANES * DATA_W;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic [TOTAL_W-1:0] total;
  logic               src_vld;
  logic               src_rdy;
  logic [OP_W-1:0]    src_a, src_b;
  logic [OP_W-1:0]    dut_op_a, dut_op_b;
  logic               dut_pvld;
  logic [RW-1:0]      gm_res, fm_res;
  logic               chk_vld;
  logic [LANES-1:0]   chk_mismatch;
  logic [CNT_W-1:0]   mis_cnt;
  logic [LANES-1:0]   lane_err;
  logic               busy, done;
`ifdef FINJ_FIRST_MISMATCH_CAPTURE_EN
  logic [TOTAL_W-1:0] first_idx;
  logic [RW-1:0]      first_gm, first_fm;
  logic               first_vld;
`endif

  // Second instance with a 2-bit counter sees identical traffic to exercise saturation.
  logic               s_src_rdy;
  logic [OP_W-1:0]    s_op_a, s_op_b;
  logic               s_pvld, s_chk_vld, s_busy, s_done;
  logic [LANES-1:0]   s_chk_mismatch, s_lane_err;
  logic [1:0]         s_mis_cnt;
`ifdef FINJ_FIRST_MISMATCH_CAPTURE_EN
  logic [TOTAL_W-1:0] s_first_idx;
  logic [RW-1:0]      s_first_gm, s_first_fm;
  logic               s_first_vld;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [RW-1:0] mask_tbl [0:63];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  finj_lockstep_checker #(
    .OP_W(OP_W), .DATA_W(DATA_W), .LANES(LANES), .LAT(LAT), .CNT_W(CNT_W), .TOTAL_W(TOTAL_W)
  ) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .start(start), .total(total),
    .src_vld(src_vld), .src_rdy(src_rdy), .src_a(src_a), .src_b(src_b),
    .dut_op_a(dut_op_a), .dut_op_b(dut_op_b), .dut_pvld(dut_pvld),
    .gm_res(gm_res), .fm_res(fm_res), .chk_vld(chk_vld), .chk_mismatch(chk_mismatch),
    .mis_cnt(mis_cnt), .lane_err(lane_err), .busy(busy), .done(done)
`ifdef FINJ_FIRST_MISMATCH_CAPTURE_EN
    , .first_idx(first_idx), .first_gm(first_gm), .first_fm(first_fm), .first_vld(first_vld)
`endif
  );

  finj_lockstep_checker #(
    .OP_W(OP_W), .DATA_W(DATA_W), .LANES(LANES), .LAT(LAT), .CNT_W(2), .TOTAL_W(TOTAL_W)
  ) dut_sat (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .start(start), .total(total),
    .src_vld(src_vld), .src_rdy(s_src_rdy), .src_a(src_a), .src_b(src_b),
    .dut_op_a(s_op_a), .dut_op_b(s_op_b), .dut_pvld(s_pvld),
    .gm_res(gm_res), .fm_res(fm_res), .chk_vld(s_chk_vld), .chk_mismatch(s_chk_mismatch),
    .mis_cnt(s_mis_cnt), .lane_err(s_lane_err), .busy(s_busy), .done(s_done)
`ifdef FINJ_FIRST_MISMATCH_CAPTURE_EN
    , .first_idx(s_first_idx), .first_gm(s_first_gm), .first_fm(s_first_fm), .first_vld(s_first_vld)
`endif
  );

  // Behavioural GM/FM pair: LAT-cycle pipeline, FM = GM xor a per-operation fault mask.
  logic [OP_W-1:0] pa [LAT];
  logic [OP_W-1:0] pb [LAT];
  logic            pv [LAT];
  int              pidx [LAT];
  int              op_seen;

  function automatic logic [RW-1:0] golden(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_seen <= 0;
      for (int i = 0; i < LAT; i++) begin
        pa[i] <= '0; pb[i] <= '0; pv[i] <= 1'b0; pidx[i] <= 0;
      end
    end else begin
      pa[0] <= dut_op_a; pb[0] <= dut_op_b; pv[0] <= dut_pvld; pidx[0] <= op_seen;
      for (int i = 1; i < LAT; i++) begin
        pa[i] <= pa[i-1]; pb[i] <= pb[i-1]; pv[i] <= pv[i-1]; pidx[i] <= pidx[i-1];
      end
      if (start) op_seen <= 0;
      else if (dut_pvld) op_seen <= op_seen + 1;
    end
  end

  assign gm_res = golden(pa[LAT-1], pb[LAT-1]);
  assign fm_res = gm_res ^ (pv[LAT-1] ? mask_tbl[pidx[LAT-1]] : '0);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase, issue/check counts and a schedule of expected compares.
  typedef struct {
    int               cyc;
    logic [LANES-1:0] mis;
  } exp_t;

  exp_t             sched[$];
  int               m_phase;
  int               m_total, m_issued, m_checked;
  logic [CNT_W-1:0] m_mis;
  logic [1:0]       m_sat;
  logic [LANES-1:0] m_lane_err;
  logic             m_pvld;
  logic [OP_W-1:0]  m_opa, m_opb;
  logic             m_first_vld;
  int               m_first_idx;

  always @(negedge clk) begin : model
    logic             exp_chk;
    logic             cur_rdy;
    exp_t             e;
    exp_t             ne;
    logic [RW-1:0]    mk;
    if (!rstn) begin
      sched.delete();
      m_phase = 0; m_total = 0; m_issued = 0; m_checked = 0;
      m_mis = '0; m_sat = '0; m_lane_err = '0; m_pvld = 1'b0;
      m_opa = '0; m_opb = '0; m_first_vld = 1'b0; m_first_idx = 0;
      checkOutput("reset_ctrl", 64'({src_rdy, dut_pvld, chk_vld, busy, done}), 64'd0);
      checkOutput("reset_counts", 64'({mis_cnt, lane_err, chk_mismatch}), 64'd0);
      checkOutput("reset_ops", {dut_op_a, dut_op_b}, 64'd0);
    end else begin
      exp_chk = (sched.size() > 0) && (sched[0].cyc == cyc);
      if (exp_chk) begin
        e = sched.pop_front();
        if (|e.mis) begin
          if (!m_first_vld) begin
            m_first_vld = 1'b1;
            m_first_idx = m_checked;
          end
          m_mis++;
          if (m_sat != 2'd3) m_sat++;
        end
        m_lane_err |= e.mis;
        m_checked++;
      end
      cur_rdy = (m_phase == 1) && (m_issued < m_total);

      checkOutput("src_rdy", 64'(src_rdy), 64'(cur_rdy));
      checkOutput("dut_pvld", 64'(dut_pvld), 64'(m_pvld));
      checkOutput("dut_op_a", 64'(dut_op_a), 64'(m_opa));
      checkOutput("dut_op_b", 64'(dut_op_b), 64'(m_opb));
      checkOutput("chk_vld", 64'(chk_vld), 64'(exp_chk));
      if (exp_chk) checkOutput("chk_mismatch", 64'(chk_mismatch), 64'(e.mis));
      checkOutput("mis_cnt", 64'(mis_cnt), 64'(m_mis));
      checkOutput("mis_cnt_sat", 64'(s_mis_cnt), 64'(m_sat));
      checkOutput("lane_err", 64'(lane_err), 64'(m_lane_err));
      checkOutput("busy", 64'(busy), 64'(m_phase == 1));
      checkOutput("done", 64'(done), 64'(m_phase == 2));
`ifdef FINJ_FIRST_MISMATCH_CAPTURE_EN
      checkOutput("first_vld", 64'(first_vld), 64'(m_first_vld));
      checkOutput("first_idx", 64'(first_idx), 64'(m_first_vld ? m_first_idx : 0));
`endif

      if ((m_phase == 1) && exp_chk && (m_checked == m_total)) m_phase = 2;
      m_pvld = 1'b0;
      if (src_vld && cur_rdy) begin
        mk = mask_tbl[m_issued];
        for (int i = 0; i < LANES; i++) ne.mis[i] = |mk[i*DATA_W +: DATA_W];
        ne.cyc = cyc + 2 + LAT;
        sched.push_back(ne);
        m_pvld = 1'b1;
        m_opa = src_a;
        m_opb = src_b;
        m_issued++;
      end
      if (start && (m_phase != 1)) begin
        m_total = int'(total);
        m_issued = 0; m_checked = 0;
        m_mis = '0; m_sat = '0; m_lane_err = '0;
        m_first_vld = 1'b0; m_first_idx = 0;
        m_phase = (total == '0) ? 2 : 1;
      end
    end
  end

  // One run: start pulse, then src_vld per mode (0 always, 1 alternating, 2 random) until done.
  task automatic applyStimulus(input int n, input int mode, output int pulses,
                               output logic [LANES-1:0] third_mis);
    bit fin;
    pulses = 0;
    third_mis = '0;
    fin = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    total = TOTAL_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cy = 0; cy < 300; cy++) begin
      case (mode)
        0:       src_vld = 1'b1;
        1:       src_vld = (cy % 2 == 0);
        default: src_vld = 1'($urandom_range(0, 1));
      endcase
      src_a = $urandom;
      src_b = $urandom;
      @(negedge clk);
      if (chk_vld) begin
        pulses++;
        if (pulses == 3) third_mis = chk_mismatch;
      end
      if (done) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!fin) checkOutput("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    src_vld = 1'b0;
  endtask

  initial begin : driver
    int               pulses;
    logic [LANES-1:0] third;
    int               post_pulses;
    rstn = 1'b0; start = 1'b0; total = '0; src_vld = 1'b0; src_a = '0; src_b = '0;
    for (int i = 0; i < 64; i++) mask_tbl[i] = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_done", 64'(done), 64'd0);

    // All lanes agree.
    applyStimulus(4, 0, pulses, third);
    checkOutput("clean_pulses", 64'(pulses), 64'd4);
    checkOutput("clean_mis_cnt", 64'(mis_cnt), 64'd0);
    checkOutput("clean_lane_err", 64'(lane_err), 64'd0);
    checkOutput("clean_done", 64'(done), 64'd1);

    // Lane 1 flips bit 0 on the third result only.
    mask_tbl[2] = 32'h0001_0000;
    applyStimulus(4, 0, pulses, third);
    checkOutput("inj_third_mis", 64'(third), 64'b10);
    checkOutput("inj_mis_cnt", 64'(mis_cnt), 64'd1);
    checkOutput("inj_lane_err", 64'(lane_err), 64'b10);
`ifdef FINJ_FIRST_MISMATCH_CAPTURE_EN
    checkOutput("inj_first_idx", 64'(first_idx), 64'd2);
    checkOutput("inj_first_diff", 64'(first_gm ^ first_fm), 64'h0001_0000);
`endif
    mask_tbl[2] = '0;

    // Empty run completes immediately and clears the counters.
    applyStimulus(0, 0, pulses, third);
    checkOutput("zero_pulses", 64'(pulses), 64'd0);
    checkOutput("zero_done", 64'(done), 64'd1);
    checkOutput("zero_mis_cnt", 64'(mis_cnt), 64'd0);

    // Gapped source.
    applyStimulus(3, 1, pulses, third);
    checkOutput("gap_pulses", 64'(pulses), 64'd3);

    // Every result mismatches: narrow counter saturates.
    for (int i = 0; i < 6; i++) mask_tbl[i] = RW'($urandom) | RW'(1);
    applyStimulus(6, 2, pulses, third);
    checkOutput("sat_pulses", 64'(pulses), 64'd6);
    checkOutput("sat_mis_cnt_wide", 64'(mis_cnt), 64'd6);
    checkOutput("sat_mis_cnt_2b", 64'(s_mis_cnt), 64'd3);

    // Random runs with random fault masks and random source gaps.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < 64; i++)
        mask_tbl[i] = ($urandom_range(0, 2) == 0) ? RW'($urandom) : '0;
      applyStimulus(n, 2, pulses, third);
      checkOutput("rand_pulses", 64'(pulses), 64'(n));
    end

    // Reset during DRAIN with two operations in flight.
    @(posedge clk); #1;
    start = 1'b1; total = TOTAL_W'(2);
    @(posedge clk); #1;
    start = 1'b0; src_vld = 1'b1; src_a = $urandom; src_b = $urandom;
    @(posedge clk); #1;
    src_a = $urandom; src_b = $urandom;
    @(posedge clk); #1;
    src_vld = 1'b0;
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_async_ctrl", 64'({dut_pvld, chk_vld, busy, done, src_rdy}), 64'd0);
    checkOutput("rst_async_cnt", 64'(mis_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    post_pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (chk_vld) post_pulses++;
    end
    checkOutput("rst_no_chk", 64'(post_pulses), 64'd0);
    checkOutput("rst_idle", 64'({busy, done}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
